// File: rtl/alu_shift_seq.sv
// Multi-bit shift/rotate sequencer: drives an external single-step ALU once per cycle
// until the requested step count is exhausted, then pulses done for one cycle.
module alu_shift_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] operand,
  input  logic [4:0]  count,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  opc_q, opc_d;
  logic        accept;

  // Requests are only taken when no run is in flight; DONE allows back-to-back.
  assign accept = start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          acc_d   = operand;
          cnt_d   = count;
          opc_d   = op;
          state_d = (count == 5'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        acc_d = alu_r;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      cnt_q   <= 5'd0;
      opc_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = acc_q;
  assign alu_a  = acc_q;
  assign alu_b  = 16'h0000;
  // op 0..3 maps onto ALU opcodes 2..5.
  assign alu_op = {2'b00, opc_q} + 4'd2;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed scenarios plus random traffic, all
// compared each cycle against a closed-form model of the accepted request.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [15:0] operand;
  logic [4:0]  count;
  logic        busy, done;
  logic [15:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_op;

  int errors = 0;
  int checks = 0;

  alu_shift_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .operand (operand),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_r   (alu_r)
  );

  always #5 clk = ~clk;

  // Single-step ALU stand-in; unknown opcodes return a marker value.
  always_comb begin
    case (alu_op)
      4'd2:    alu_r = {alu_a[14:0], 1'b0};
      4'd3:    alu_r = {1'b0, alu_a[15:1]};
      4'd4:    alu_r = {alu_a[14:0], alu_a[15]};
      4'd5:    alu_r = {alu_a[0], alu_a[15:1]};
      default: alu_r = 16'hDEAD;
    endcase
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Value after n single-bit steps of operation o, in closed form.
  function automatic logic [15:0] apply_n(input logic [1:0] o, input logic [15:0] v,
                                          input int n);
    logic [31:0] w;
    int          r;
    w = {16'h0000, v};
    r = n % 16;
    case (o)
      2'd0:    w = w << n;
      2'd1:    w = w >> n;
      2'd2:    w = (w << r) | (w >> (16 - r));
      default: w = (w >> r) | (w << (16 - r));
    endcase
    return w[15:0];
  endfunction

  // Model: the last accepted request and the number of edges since it was accepted.
  bit          m_valid = 1'b0;
  logic [1:0]  m_op;
  logic [15:0] m_opnd;
  int          m_cnt, m_k;
  bit          m_busy, e_busy, e_done;
  logic [15:0] e_acc;
  logic [3:0]  e_op;
  int          steps;

  always @(negedge clk) begin
    m_busy = m_valid && (m_k <= m_cnt);
    if (reset) begin
      m_valid = 1'b0;
    end else if (start && !m_busy) begin
      m_valid = 1'b1;
      m_op    = op;
      m_opnd  = operand;
      m_cnt   = int'(count);
      m_k     = 1;
    end else if (m_valid && m_k < 1000) begin
      m_k++;
    end
    if (m_valid) begin
      steps  = (m_k - 1 < m_cnt) ? m_k - 1 : m_cnt;
      e_acc  = apply_n(m_op, m_opnd, steps);
      e_busy = (m_k <= m_cnt);
      e_done = (m_k == m_cnt + 1);
      e_op   = 4'(m_op) + 4'd2;
    end else begin
      e_acc  = 16'h0000;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_op   = 4'd2;
    end
    check("busy",   {15'b0, busy},  {15'b0, e_busy});
    check("done",   {15'b0, done},  {15'b0, e_done});
    check("result", result,         e_acc);
    check("alu_a",  alu_a,          e_acc);
    check("alu_op", {12'b0, alu_op}, {12'b0, e_op});
    check("alu_b",  alu_b,          16'h0000);
  end

  // Drive one cycle of inputs; returns just after the following falling edge.
  task automatic step(input logic r, input logic s, input logic [1:0] o,
                      input logic [15:0] v, input logic [4:0] c);
    reset   = r;
    start   = s;
    op      = o;
    operand = v;
    count   = c;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 16'h0000, 5'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; operand = 16'h0000; count = 5'd0;
    step(1'b1, 1'b0, 2'd0, 16'h0000, 5'd0);
    step(1'b1, 1'b0, 2'd0, 16'h0000, 5'd0);
    check("reset_result", result, 16'h0000);
    check("reset_alu_op", {12'b0, alu_op}, 16'd2);
    check("reset_busy", {15'b0, busy}, 16'd0);

    // count=0 completes on the next cycle without ever going busy
    step(1'b0, 1'b1, 2'd0, 16'hABCD, 5'd0);
    check("cnt0_done", {15'b0, done}, 16'd1);
    check("cnt0_result", result, 16'hABCD);
    idle(1);
    check("cnt0_hold", result, 16'hABCD);

    // SHL 0x0001 by 4
    step(1'b0, 1'b1, 2'd0, 16'h0001, 5'd4);
    check("shl_busy_t1", {15'b0, busy}, 16'd1);
    idle(3);
    check("shl_busy_t4", {15'b0, busy}, 16'd1);
    idle(1);
    check("shl_done_t5", {15'b0, done}, 16'd1);
    check("shl_result", result, 16'h0010);

    // SHR 0xFFFF by 31
    step(1'b0, 1'b1, 2'd1, 16'hFFFF, 5'd31);
    idle(31);
    check("shr31_done", {15'b0, done}, 16'd1);
    check("shr31_result", result, 16'h0000);

    // ROR 0x0001 by 1
    step(1'b0, 1'b1, 2'd3, 16'h0001, 5'd1);
    idle(1);
    check("ror_done", {15'b0, done}, 16'd1);
    check("ror_result", result, 16'h8000);

    // start while busy is dropped; start in the done cycle is taken
    step(1'b0, 1'b1, 2'd0, 16'h0005, 5'd3);
    step(1'b0, 1'b1, 2'd3, 16'h1234, 5'd0);
    idle(2);
    check("b2b_first_done", {15'b0, done}, 16'd1);
    check("b2b_first_result", result, 16'h0028);
    step(1'b0, 1'b1, 2'd2, 16'h8001, 5'd2);
    check("b2b_second_busy", {15'b0, busy}, 16'd1);
    idle(2);
    check("b2b_second_done", {15'b0, done}, 16'd1);
    check("b2b_second_result", result, 16'h0006);

    // reset during the third RUN cycle of a count=8 request
    idle(1);
    step(1'b0, 1'b1, 2'd0, 16'h0003, 5'd8);
    idle(2);
    check("abort_busy_before", {15'b0, busy}, 16'd1);
    step(1'b1, 1'b0, 2'd0, 16'h0000, 5'd0);
    check("abort_busy", {15'b0, busy}, 16'd0);
    check("abort_done", {15'b0, done}, 16'd0);
    check("abort_result", result, 16'h0000);
    check("abort_alu_op", {12'b0, alu_op}, 16'd2);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("abort_no_done", {15'b0, done}, 16'd0);
    end

    // start coincident with reset is ignored
    step(1'b1, 1'b1, 2'd2, 16'hFFFF, 5'd0);
    check("rst_start_done", {15'b0, done}, 16'd0);
    check("rst_start_result", result, 16'h0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r, s;
      logic [4:0] c;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      step(r, s, 2'($urandom_range(0, 3)), 16'($urandom), c);
    end
    step(1'b0, 1'b0, 2'd0, 16'h0000, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
